// File: rtl/fft_power_avg.sv
// fft_power_avg: per-bin |X|^2 averaged over 2^A frames, streamed out bin-serially.
// Latency: 3 cycles from an accepted bin to its FIFO push (final frame only); m_* is the FIFO head.
// Backpressure: s_ready drops only when a final-frame bin could overflow the 4-deep output FIFO.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   clear                 synchronous restart of the average; flushes pipeline and FIFO
//   cfg_avg_log2          log2 of frames per average, latched at the start of each average
//   s_valid/s_ready       input bin handshake; s_re/s_im signed bin value, s_last ends a frame
//   m_valid/m_ready       output handshake; m_power averaged power, m_bin index, m_last on last bin
//   err                   one-cycle pulse after a bin arrives with the wrong frame position
// Optional: define FFT_POWER_AVG_PEAK_EN to add peak_bin/peak_valid (peak bin of each output frame).
module fft_power_avg #(
  parameter int DATA_W       = 24,
  parameter int NPTS         = 8,
  parameter int MAX_AVG_LOG2 = 4,
  localparam int PWR_W       = 2*DATA_W+1,
  localparam int CFG_W       = $clog2(MAX_AVG_LOG2+1),
  localparam int BIN_W       = $clog2(NPTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [CFG_W-1:0]  cfg_avg_log2,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_re,
  input  logic [DATA_W-1:0] s_im,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PWR_W-1:0]  m_power,
  output logic [BIN_W-1:0]  m_bin,
  output logic              m_last,
  output logic              err
`ifdef FFT_POWER_AVG_PEAK_EN
  ,
  output logic [BIN_W-1:0]  peak_bin,
  output logic              peak_valid
`endif
);

  localparam int ACC_W = PWR_W + MAX_AVG_LOG2;
  localparam int FRM_W = MAX_AVG_LOG2;
  localparam int SQ_W  = 2*DATA_W;
  localparam int FD    = 4;

  // ---------------- control / frame counters ----------------
  logic             rdy_en;
  logic [BIN_W-1:0] bin_cnt;
  logic [FRM_W-1:0] frm_cnt;
  logic [CFG_W-1:0] a_lat;
  logic [CFG_W-1:0] cfg_sat;
  logic [CFG_W-1:0] a_eff;
  logic [FRM_W-1:0] fin_mask;
  logic             at_start, next_first, next_final, bin_is_end, len_err;
  logic             acc_in, take;
  logic [3:0]       occ;
  logic             room;

  // stage 1
  logic             v1, last1, first1, fin1;
  logic [BIN_W-1:0] bin1;
  logic [CFG_W-1:0] a1;
  logic [SQ_W-1:0]  sq_re1, sq_im1;
  // stage 2
  logic             v2, last2, first2, fin2;
  logic [BIN_W-1:0] bin2;
  logic [CFG_W-1:0] a2;
  logic [PWR_W-1:0] pwr2;
  logic [ACC_W-1:0] rd2;
  // stage 3 (combinational from stage 2)
  logic [ACC_W-1:0] sum3, acc3;
  logic [PWR_W-1:0] avg3;
  logic             wr_en, push, pop;

  logic [ACC_W-1:0] mem [NPTS];

  logic [PWR_W-1:0] f_pwr  [FD];
  logic [BIN_W-1:0] f_bin  [FD];
  logic             f_last [FD];
  logic [1:0]       wp, rp;
  logic [2:0]       fcnt;

  logic signed [SQ_W-1:0] re_ext, im_ext;

  assign cfg_sat    = (cfg_avg_log2 > CFG_W'(MAX_AVG_LOG2)) ? CFG_W'(MAX_AVG_LOG2) : cfg_avg_log2;
  assign at_start   = (bin_cnt == '0) && (frm_cnt == '0);
  // The depth that will govern the next bin: a fresh average picks up cfg directly.
  assign a_eff      = at_start ? cfg_sat : a_lat;
  assign fin_mask   = ~({FRM_W{1'b1}} << a_eff);
  assign next_first = (frm_cnt == '0);
  assign next_final = (frm_cnt == fin_mask);
  assign bin_is_end = (bin_cnt == BIN_W'(NPTS-1));
  assign len_err    = s_last ^ bin_is_end;

  // Only bins headed for the FIFO count against its space, so accumulate
  // frames keep flowing even while the consumer stalls.
  assign occ     = {1'b0, fcnt} + {3'b000, v1 & fin1} + {3'b000, v2 & fin2};
  assign room    = (occ < 4'd4);
  assign s_ready = rdy_en && !clear && (!next_final || room);
  assign acc_in  = s_valid && s_ready;
  assign take    = acc_in && !len_err;

  assign re_ext = SQ_W'($signed(s_re));
  assign im_ext = SQ_W'($signed(s_im));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en  <= 1'b0;
      err     <= 1'b0;
      bin_cnt <= '0;
      frm_cnt <= '0;
      a_lat   <= '0;
      v1      <= 1'b0;
      last1   <= 1'b0;
      first1  <= 1'b0;
      fin1    <= 1'b0;
      bin1    <= '0;
      a1      <= '0;
      sq_re1  <= '0;
      sq_im1  <= '0;
      v2      <= 1'b0;
      last2   <= 1'b0;
      first2  <= 1'b0;
      fin2    <= 1'b0;
      bin2    <= '0;
      a2      <= '0;
      pwr2    <= '0;
    end else begin
      rdy_en <= 1'b1;
      err    <= acc_in && len_err;

      // P1: squares. take is already low under clear.
      v1 <= take;
      if (take) begin
        bin1   <= bin_cnt;
        last1  <= s_last;
        first1 <= next_first;
        fin1   <= next_final;
        a1     <= a_eff;
        sq_re1 <= re_ext * re_ext;
        sq_im1 <= im_ext * im_ext;
      end

      // P2: power sum (RAM read happens in the memory block below).
      v2 <= v1 && !clear;
      if (v1) begin
        bin2   <= bin1;
        last2  <= last1;
        first2 <= first1;
        fin2   <= fin1;
        a2     <= a1;
        pwr2   <= PWR_W'(sq_re1) + PWR_W'(sq_im1);
      end

      if (clear) begin
        bin_cnt <= '0;
        frm_cnt <= '0;
      end else if (acc_in) begin
        if (len_err) begin
          bin_cnt <= '0;
          frm_cnt <= '0;
        end else begin
          if (at_start) a_lat <= cfg_sat;
          if (bin_is_end) begin
            bin_cnt <= '0;
            frm_cnt <= next_final ? '0 : frm_cnt + FRM_W'(1);
          end else begin
            bin_cnt <= bin_cnt + BIN_W'(1);
          end
        end
      end
    end
  end

  // P3: first frame overwrites, later frames add; the final frame goes to the FIFO.
  assign sum3  = rd2 + ACC_W'(pwr2);
  assign acc3  = first2 ? ACC_W'(pwr2) : sum3;
  assign avg3  = PWR_W'(acc3 >> a2);
  assign wr_en = v2 && !fin2 && !clear;
  assign push  = v2 && fin2 && !clear;
  assign pop   = m_valid && m_ready;

  // Bins in flight always hit distinct addresses (NPTS >= 4), so no bypass.
  always_ff @(posedge clk) begin
    if (wr_en) mem[bin2] <= acc3;
    if (v1)    rd2 <= mem[bin1];
  end

  // ---------------- output FIFO ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FD; i++) begin
        f_pwr[i]  <= '0;
        f_bin[i]  <= '0;
        f_last[i] <= 1'b0;
      end
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else if (clear) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) begin
        f_pwr[wp]  <= avg3;
        f_bin[wp]  <= bin2;
        f_last[wp] <= last2;
        wp         <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      fcnt <= fcnt + 3'(push) - 3'(pop);
    end
  end

  assign m_valid = (fcnt != 3'd0);
  assign m_power = f_pwr[rp];
  assign m_bin   = f_bin[rp];
  assign m_last  = f_last[rp];

`ifdef FFT_POWER_AVG_PEAK_EN
  // ---------------- peak tracker ----------------
  logic             pk_open;
  logic [PWR_W-1:0] pk_max;
  logic [BIN_W-1:0] pk_run;
  logic             new_best;

  // Strict > keeps the lowest bin on ties.
  assign new_best = !pk_open || (m_power > pk_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_open    <= 1'b0;
      pk_max     <= '0;
      pk_run     <= '0;
      peak_bin   <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (clear) begin
        pk_open <= 1'b0;
      end else if (pop) begin
        if (new_best) begin
          pk_max <= m_power;
          pk_run <= m_bin;
        end
        if (m_last) begin
          pk_open    <= 1'b0;
          peak_valid <= 1'b1;
          peak_bin   <= new_best ? m_bin : pk_run;
        end else begin
          pk_open <= 1'b1;
        end
      end
    end
  end
`else
  // Peak tracking not built.
`endif

endmodule

// File: tb/tb_fft_power_avg.sv
module tb_fft_power_avg;
  localparam int DATA_W = 24;
  localparam int NPTS   = 8;
  localparam int MAX_A  = 4;
  localparam int PWR_W  = 2*DATA_W+1;
  localparam int BIN_W  = 3;
  localparam int CFG_W  = 3;

  logic              clk = 1'b0;
  logic              rst, clear;
  logic [CFG_W-1:0]  cfg;
  logic              s_valid, s_ready, s_last;
  logic [DATA_W-1:0] s_re, s_im;
  logic              m_valid, m_ready, m_last, err;
  logic [PWR_W-1:0]  m_power;
  logic [BIN_W-1:0]  m_bin;
`ifdef FFT_POWER_AVG_PEAK_EN
  logic [BIN_W-1:0]  peak_bin;
  logic              peak_valid;
  int                pk_cnt = 0;
  int                pk_seen = 0;
`endif

  fft_power_avg #(.DATA_W(DATA_W), .NPTS(NPTS), .MAX_AVG_LOG2(MAX_A)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_avg_log2(cfg),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_power(m_power), .m_bin(m_bin),
    .m_last(m_last), .err(err)
`ifdef FFT_POWER_AVG_PEAK_EN
    , .peak_bin(peak_bin), .peak_valid(peak_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [PWR_W-1:0] pwr;
    int               bin;
    bit               last;
  } ob_t;

  ob_t    exp_q[$];
  ob_t    cap_q[$];
  ob_t    mon_o, mon_e;
  longint acc_m[NPTS];
  int     mbin = 0, mfrm = 0, mA = 0;
  bit     err_pend = 0;
  int     accepted = 0, err_seen = 0;

  task automatic model_reset();
    exp_q.delete();
    mbin = 0;
    mfrm = 0;
    err_pend = 0;
  endtask

  // Averaging rule: frame sums of each bin over 2^A frames, divided by 2^A.
  task automatic model_accept(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                              input logic last);
    longint p;
    int     nfr;
    accepted++;
    if (mbin == 0 && mfrm == 0) mA = (int'(cfg) > MAX_A) ? MAX_A : int'(cfg);
    if (last != (mbin == NPTS-1)) begin
      err_pend = 1;
      mbin = 0;
      mfrm = 0;
      return;
    end
    nfr = 1 << mA;
    p = longint'($signed(re)) * longint'($signed(re)) + longint'($signed(im)) * longint'($signed(im));
    acc_m[mbin] = (mfrm == 0) ? p : acc_m[mbin] + p;
    if (mfrm == nfr - 1) exp_q.push_back('{PWR_W'(acc_m[mbin] / longint'(nfr)), mbin, last});
    if (last) begin
      mbin = 0;
      mfrm = (mfrm == nfr - 1) ? 0 : mfrm + 1;
    end else begin
      mbin++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      if (err || err_pend) check("err_pulse", err, err_pend);
      err_pend = 0;
      if (err) err_seen++;
      if (m_valid && m_ready) begin
        mon_o = '{m_power, int'(m_bin), m_last};
        cap_q.push_back(mon_o);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got bin %0d power %0d, expected no output", m_bin, m_power);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_power", m_power, mon_e.pwr);
          check("out_bin", m_bin, mon_e.bin);
          check("out_last", m_last, mon_e.last);
        end
      end
      if (clear) check("clear_blocks_ready", s_ready, 0);
      if (s_valid && s_ready) model_accept(s_re, s_im, s_last);
      if (clear) begin
        exp_q.delete();
        mbin = 0;
        mfrm = 0;
      end
`ifdef FFT_POWER_AVG_PEAK_EN
      if (peak_valid) begin
        pk_cnt++;
        pk_seen = int'(peak_bin);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  bit   rand_mr = 0;
  logic mr_force = 1'b1;

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_mr ? 1'($urandom_range(0, 1)) : mr_force;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im, input logic last);
    int n = 0;
    bit ok = 0;
    s_valid = 1'b1;
    s_re = re;
    s_im = im;
    s_last = last;
    while (!ok) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 3000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: s_ready stayed %0d, expected 1", s_ready);
        ok = 1;
      end
    end
    s_valid = 1'b0;
  endtask

  logic [DATA_W-1:0] fre[NPTS], fim[NPTS];
  bit frame_done;

  task automatic send_frame(input int gapmax);
    for (int k = 0; k < NPTS; k++) begin
      send(fre[k], fim[k], k == NPTS-1);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
    frame_done = 1;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NPTS; k++) begin
      fre[k] = DATA_W'($urandom);
      fim[k] = DATA_W'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still expected, expected 0", exp_q.size());
    end
    idle(3);
  endtask

  typedef struct {
    logic [DATA_W-1:0] re, im;
    logic              last;
    logic [PWR_W-1:0]  exp_pwr;
    logic [BIN_W-1:0]  exp_bin;
    logic              exp_last;
  } vec_t;

  vec_t tv[NPTS];
  int   exp1[NPTS] = '{2, 8, 18, 32, 50, 72, 98, 128};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, e0;
    rst = 1; clear = 0; cfg = 0; s_valid = 0; s_re = 0; s_im = 0; s_last = 0;
    frame_done = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_power", m_power, 0);
    check("rst_m_bin", m_bin, 0);
    check("rst_m_last", m_last, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rdy_first_cycle", s_ready, 0);
    @(negedge clk);
    check("rdy_after", s_ready, 1);
    @(posedge clk); #1;

    // A=0, bin k = (k+1, -(k+1)): table of inputs and expected outputs
    for (int k = 0; k < NPTS; k++) begin
      tv[k].re       = DATA_W'(k + 1);
      tv[k].im       = DATA_W'(-(k + 1));
      tv[k].last     = (k == NPTS-1);
      tv[k].exp_pwr  = PWR_W'(exp1[k]);
      tv[k].exp_bin  = BIN_W'(k);
      tv[k].exp_last = (k == NPTS-1);
    end
    cap_q.delete();
    cfg = 0;
    for (int k = 0; k < NPTS; k++) send(tv[k].re, tv[k].im, tv[k].last);
    drain();
    check("t1_count", cap_q.size(), NPTS);
    for (int k = 0; k < NPTS && k < cap_q.size(); k++) begin
      check("t1_power", cap_q[k].pwr, tv[k].exp_pwr);
      check("t1_bin", cap_q[k].bin, tv[k].exp_bin);
      check("t1_last", cap_q[k].last, tv[k].exp_last);
    end

    // A=2, bin3 re = 10,20,30,40 -> 750
    cap_q.delete();
    cfg = 2;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NPTS; k++) begin
        fre[k] = (k == 3) ? DATA_W'(10 * (f + 1)) : '0;
        fim[k] = '0;
      end
      send_frame(0);
    end
    drain();
    check("t2_count", cap_q.size(), NPTS);
    if (cap_q.size() == NPTS) begin
      check("t2_bin3", cap_q[3].pwr, 750);
      check("t2_bin0", cap_q[0].pwr, 0);
    end

    // Max magnitude at maximum depth
    cap_q.delete();
    cfg = 3'(MAX_A);
    for (int k = 0; k < NPTS; k++) begin
      fre[k] = 24'h800000;
      fim[k] = 24'h800000;
    end
    for (int f = 0; f < (1 << MAX_A); f++) send_frame(0);
    drain();
    check("t3_count", cap_q.size(), NPTS);
    if (cap_q.size() == NPTS) begin
      check("t3_pwr0", cap_q[0].pwr, 64'd140737488355328);
      check("t3_pwr7", cap_q[7].pwr, 64'd140737488355328);
    end

    // Final frame with m_ready low: stall after 4 bins, then resume
    cap_q.delete();
    cfg = 0;
    mr_force = 0;
    idle(2);
    for (int k = 0; k < NPTS; k++) begin
      fre[k] = DATA_W'(k + 3);
      fim[k] = DATA_W'(k);
    end
    a0 = accepted;
    frame_done = 0;
    fork
      send_frame(0);
    join_none
    idle(20);
    check("t4_accepted", accepted - a0, 4);
    check("t4_s_ready", s_ready, 0);
    check("t4_m_valid", m_valid, 1);
    check("t4_head_bin", m_bin, 0);
    mr_force = 1;
    for (int n = 0; n < 200 && !frame_done; n++) idle(1);
    check("t4_frame_done", frame_done, 1);
    drain();
    check("t4_count", cap_q.size(), NPTS);
    for (int k = 0; k < NPTS && k < cap_q.size(); k++) check("t4_order", cap_q[k].bin, k);

    // Frame-length errors
    cap_q.delete();
    e0 = err_seen;
    cfg = 1;
    for (int k = 0; k < 6; k++) send(DATA_W'(k), 0, k == 5);
    idle(3);
    check("t5_err_early_last", err_seen - e0, 1);
    cfg = 0;
    rand_frame();
    send_frame(0);
    drain();
    check("t5_relatch_count", cap_q.size(), NPTS);
    for (int k = 0; k < NPTS; k++) send(DATA_W'(k + 1), DATA_W'(2), 1'b0);
    idle(3);
    check("t5_err_missing_last", err_seen - e0, 2);
    drain();
    check("t5_partial_count", cap_q.size(), 2*NPTS - 1);
    rand_frame();
    send_frame(1);
    drain();
    check("t5_recover_count", cap_q.size(), 3*NPTS - 1);

    // clear mid-average, with s_valid asserted during clear
    cap_q.delete();
    cfg = 2;
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      send_frame(0);
    end
    s_valid = 1; s_re = 5; s_im = 5; s_last = 0;
    clear = 1;
    idle(1);
    clear = 0;
    s_valid = 0;
    idle(4);
    check("t6_clear_no_out", cap_q.size(), 0);
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(1);
    end
    drain();
    check("t6_after_clear_count", cap_q.size(), NPTS);

    // clear flushes buffered output words
    cap_q.delete();
    cfg = 0;
    mr_force = 0;
    idle(2);
    for (int k = 0; k < 3; k++) send(DATA_W'(k + 7), 0, 1'b0);
    idle(5);
    check("t6_fifo_loaded", m_valid, 1);
    clear = 1;
    idle(1);
    clear = 0;
    idle(1);
    check("t6_fifo_flushed", m_valid, 0);
    mr_force = 1;
    rand_frame();
    send_frame(0);
    drain();
    check("t6_flush_count", cap_q.size(), NPTS);

    // rst mid-frame
    cfg = 1;
    rand_frame();
    send_frame(0);
    for (int k = 0; k < 3; k++) send(DATA_W'(k), DATA_W'(k), 1'b0);
    rst = 1;
    idle(2);
    check("t6_rst_m_valid", m_valid, 0);
    check("t6_rst_s_ready", s_ready, 0);
    check("t6_rst_m_power", m_power, 0);
    check("t6_rst_err", err, 0);
    rst = 0;
    cap_q.delete();
    idle(2);
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      send_frame(0);
    end
    drain();
    check("t6_after_rst_count", cap_q.size(), NPTS);

`ifdef FFT_POWER_AVG_PEAK_EN
    // Equal peaks in bins 2 and 6 -> lowest bin wins
    a0 = pk_cnt;
    cfg = 0;
    for (int k = 0; k < NPTS; k++) begin
      fre[k] = (k == 2 || k == 6) ? DATA_W'(9) : DATA_W'(1);
      fim[k] = '0;
    end
    send_frame(0);
    drain();
    check("peak_pulses", pk_cnt - a0, 1);
    check("peak_bin", pk_seen, 2);
`endif

    // Randomized averages against the model
    rand_mr = 1;
    for (int r = 0; r < 14; r++) begin
      int a;
      cfg = 3'($urandom_range(0, 5));
      a = (int'(cfg) > MAX_A) ? MAX_A : int'(cfg);
      for (int f = 0; f < (1 << a); f++) begin
        rand_frame();
        send_frame(2);
      end
    end
    rand_mr = 0;
    mr_force = 1;
    idle(2);
    drain();
    check("rand_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
